icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped instruction cache controller between the instruction fetcher and the memory controller's fetch port.
- Hits return a word one cycle after the request is accepted.
- Misses sequence a line fill as LINE_WORDS back-to-back word reads from the memory controller, then return the requested word.
- Rollback aborts the fetcher-facing transaction cleanly while still honouring the non-cancellable memory-side handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction/word width.
- IDX_W, 4, index bits; LINES = 2^IDX_W = 16.
- OFF_W, 2, word-offset bits; LINE_WORDS = 2^OFF_W = 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready; all state frozen when low.
- rollback  in  1  pipeline flush from reorder buffer.
- if_en  in  1  fetch request, held until if_done.
- if_pc  in  ADDR_W  fetch address, word aligned.
- if_done  out  1  one-cycle pulse, if_data valid.
- if_data  out  DATA_W  fetched instruction.
- mc_en  out  1  word read request to memory controller.
- mc_pc  out  ADDR_W  word address for mc_en.
- mc_done  in  1  one-cycle pulse, mc_data valid.
- mc_data  in  DATA_W  word returned by memory controller.

Behaviour:
- Address split:
  - off = pc[OFF_W+1:2]
  - idx = pc[IDX_W+OFF_W+1:OFF_W+2]
  - tag = pc[ADDR_W-1:IDX_W+OFF_W+2]
  - pc[1:0] ignored.
- Storage: per line one valid bit, one tag and LINE_WORDS data words, all registers. Only valid bits are reset.
- Reset (async, rst=1):
  - state=IDLE, all valid=0, fill counter=0, abort flag=0.
  - if_done=0, if_data=0, mc_en=0, mc_pc=0.
- rdy=0: no state, storage or output changes. mc_done/if_en are not sampled.
- IDLE:
  - if_en=1, rollback=0, hit (valid[idx] and tag match): capture request; next cycle if_done=1 and if_data=line[idx].word[off]. Stay IDLE.
  - if_en=1, rollback=0, miss: capture pc; go to FILL with counter=0 and mc_en=0. Requests are not accepted in the cycle if_done is high.
- FILL:
  - mc_en=1, mc_pc = {req_tag, req_idx, counter, 2'b00}. Fill always starts at word 0.
  - mc_en is held until mc_done.
  - On mc_done: write mc_data into line[req_idx].word[counter]; drop mc_en for exactly one cycle (GAP); then counter+1.
  - After the word with counter=LINE_WORDS-1: valid[req_idx]=1, tag[req_idx]=req_tag; go to RESP. The line is invalidated at FILL entry.
- RESP: if_done=1 for one cycle with the captured offset word; return to IDLE.
- Miss latency: LINE_WORDS × (memory latency + 1 gap) + 1 cycles from acceptance to if_done.
- Rollback:
  - IDLE: any pending hit response is suppressed (if_done stays 0). The same-cycle if_en is ignored.
  - FILL with mc_en=1: set abort flag; keep mc_en high until mc_done (memory controller cannot cancel). Discard the word; go IDLE with mc_en=0. The line stays invalid.
  - GAP: go IDLE immediately.
  - RESP: if_done suppressed; go IDLE. The line remains valid.
- mc_done while mc_en=0 is ignored.
- Counter wraps only via reset to 0 at FILL entry. No partial-line hits are allowed during a fill.
- Async reset mid-fill: returns to reset state immediately. mc_en drops combinationally with state.

Test Plan:
- Reset, then if_pc=0x0000_0010, memory returns 0x11,0x22,0x33,0x44 for 0x10..0x1C -> mc_pc sequence 0x10,0x14,0x18,0x1C; if_done with if_data=0x11. Then if_pc=0x18 -> if_done next cycle, data 0x33, mc_en stays 0.
- Conflict: fill 0x0010, then fetch 0x0110 (same idx 1, tag differs) -> miss refill at 0x110..0x11C. Then 0x0010 -> miss again.
- Rollback asserted while mc_en=1 on word 2 of the fill for 0x40 -> mc_en held until mc_done, no if_done. Later fetch 0x40 -> full refill starting at mc_pc=0x40.
- Rollback in the same cycle as a hitting if_en -> if_done never asserted. Next request accepted normally.
- rdy=0 for 5 cycles mid-fill with mc_done pulsed while rdy=0 -> no counter advance, outputs frozen. Resumes correctly when rdy=1.
- rst pulsed mid-fill, then fetch a previously cached address 0x10 -> treated as a miss, all valid bits cleared.

Source files
------------

// File: rtl/icache_ctrl_if.sv
// Fetcher-side and memory-side handshake signals of the instruction cache.
// The cache takes the slave view; the surrounding pipeline/memory take the master view.
interface icache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_en;
    logic [ADDR_W-1:0] if_pc;
    logic              if_done;
    logic [DATA_W-1:0] if_data;
    logic              mc_en;
    logic [ADDR_W-1:0] mc_pc;
    logic              mc_done;
    logic [DATA_W-1:0] mc_data;

    modport slave (
        input  if_en, if_pc, mc_done, mc_data,
        output if_done, if_data, mc_en, mc_pc
    );

    modport master (
        output if_en, if_pc, mc_done, mc_data,
        input  if_done, if_data, mc_en, mc_pc
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hits answer one cycle after acceptance,
// misses fetch the whole line word by word from the memory controller before answering.
module icache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int OFF_W  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    icache_ctrl_if.slave bus
);
    localparam int LINES      = 1 << IDX_W;
    localparam int LINE_WORDS = 1 << OFF_W;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, FILL, GAP, RESP} state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic              abort_q, abort_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [IDX_W-1:0]  req_idx_q, req_idx_d;
    logic [OFF_W-1:0]  req_off_q, req_off_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic              mc_en_q, mc_en_d;
    logic [ADDR_W-1:0] mc_pc_q, mc_pc_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][LINE_WORDS];
    logic              tag_we, data_we;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              hit;
    logic              unused_pc_lsb;

    assign pc_off        = bus.if_pc[OFF_W+1:2];
    assign pc_idx        = bus.if_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag        = bus.if_pc[ADDR_W-1:IDX_W+OFF_W+2];
    assign unused_pc_lsb = ^bus.if_pc[1:0];
    assign hit           = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign cnt_nxt       = cnt_q + OFF_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        req_off_d = req_off_q;
        valid_d   = valid_q;
        if_done_d = if_done_q;
        if_data_d = if_data_q;
        mc_en_d   = mc_en_q;
        mc_pc_d   = mc_pc_q;
        tag_we    = 1'b0;
        data_we   = 1'b0;

        if (rdy) begin
            if_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // A request still held during its own if_done cycle must not be re-accepted.
                    if (bus.if_en && !rollback && !if_done_q) begin
                        if (hit) begin
                            if_done_d = 1'b1;
                            if_data_d = data_q[pc_idx][pc_off];
                        end else begin
                            req_tag_d       = pc_tag;
                            req_idx_d       = pc_idx;
                            req_off_d       = pc_off;
                            valid_d[pc_idx] = 1'b0;
                            cnt_d           = '0;
                            abort_d         = 1'b0;
                            mc_en_d         = 1'b0;
                            state_d         = FILL;
                        end
                    end
                end
                FILL: begin
                    if (!mc_en_q) begin
                        if (rollback) begin
                            state_d = IDLE;
                        end else begin
                            mc_en_d = 1'b1;
                            mc_pc_d = {req_tag_q, req_idx_q, cnt_q, 2'b00};
                        end
                    end else if (bus.mc_done) begin
                        mc_en_d = 1'b0;
                        if (abort_q || rollback) begin
                            abort_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            data_we = 1'b1;
                            state_d = GAP;
                        end
                    end else if (rollback) begin
                        // The memory read cannot be cancelled; wait for it and drop the word.
                        abort_d = 1'b1;
                    end
                end
                GAP: begin
                    if (rollback) begin
                        state_d = IDLE;
                    end else if (&cnt_q) begin
                        valid_d[req_idx_q] = 1'b1;
                        tag_we             = 1'b1;
                        state_d            = RESP;
                    end else begin
                        cnt_d   = cnt_nxt;
                        mc_en_d = 1'b1;
                        mc_pc_d = {req_tag_q, req_idx_q, cnt_nxt, 2'b00};
                        state_d = FILL;
                    end
                end
                RESP: begin
                    if (!rollback) begin
                        if_done_d = 1'b1;
                        if_data_d = data_q[req_idx_q][req_off_q];
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            valid_q   <= '0;
            if_done_q <= 1'b0;
            if_data_q <= '0;
            mc_en_q   <= 1'b0;
            mc_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            valid_q   <= valid_d;
            if_done_q <= if_done_d;
            if_data_q <= if_data_d;
            mc_en_q   <= mc_en_d;
            mc_pc_q   <= mc_pc_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (data_we) data_q[req_idx_q][cnt_q] <= bus.mc_data;
        if (tag_we)  tag_q[req_idx_q]         <= req_tag_q;
    end

    assign bus.if_done = if_done_q;
    assign bus.if_data = if_data_q;
    assign bus.mc_en   = mc_en_q;
    assign bus.mc_pc   = mc_pc_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// Randomized bench for icache_ctrl: a random-latency memory responder plus a
// valid/tag model of the cache and a fixed memory-content function predict every fetch.
module tb_icache_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    icache_ctrl_if bus ();

    icache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mc_log[$];
    bit          mvalid[16];
    logic [23:0] mtag[16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h11;
            32'h14:  return 32'h22;
            32'h18:  return 32'h33;
            32'h1C:  return 32'h44;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
        endcase
    endfunction

    // Memory controller: answers each mc_en request after 1..3 cycles with a one-cycle mc_done.
    initial begin
        int mem_cnt;
        logic [31:0] mem_addr;
        mem_cnt = 0;
        mem_addr = '0;
        bus.mc_done = 1'b0;
        bus.mc_data = '0;
        forever begin
            @(negedge clk);
            bus.mc_done = 1'b0;
            if (rst) begin
                mem_cnt = 0;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.mc_done = 1'b1;
                    bus.mc_data = mem_word(mem_addr);
                end
            end else if (bus.mc_en === 1'b1) begin
                mem_cnt  = int'($urandom_range(1, 3));
                mem_addr = bus.mc_pc;
            end
        end
    end

    // Every memory word the controller actually consumed.
    always @(posedge clk) begin
        if (!rst && rdy && bus.mc_en === 1'b1 && bus.mc_done === 1'b1)
            mc_log.push_back(bus.mc_pc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_fetch(input logic [31:0] pc);
        bit exp_hit, got, bad;
        int cyc, l0, idx;
        logic [31:0] base, exp_data;
        logic [23:0] tg;
        idx      = int'(pc[7:4]);
        tg       = pc[31:8];
        exp_hit  = mvalid[idx] && (mtag[idx] == tg);
        base     = {pc[31:4], 4'h0};
        exp_data = mem_word({pc[31:2], 2'b00});
        @(negedge clk);
        l0 = mc_log.size();
        bus.if_en = 1'b1;
        bus.if_pc = pc;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = (bus.if_done === 1'b1);
        end
        bus.if_en = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL fetch_done pc=%h: no if_done within %0d cycles, required one pulse", pc, cyc);
        end else begin
            checks++;
            if (bus.if_data !== exp_data) begin
                failures++;
                $display("FAIL fetch_data pc=%h: got %h, required %h", pc, bus.if_data, exp_data);
            end
            checks++;
            if (exp_hit) begin
                if (cyc != 1 || mc_log.size() != l0 || bus.mc_en !== 1'b0) begin
                    failures++;
                    $display("FAIL hit_path pc=%h: latency %0d reads %0d mc_en %b, required 1/0/0",
                             pc, cyc, mc_log.size() - l0, bus.mc_en);
                end
            end else begin
                bad = (mc_log.size() - l0 != 4);
                if (!bad)
                    for (int i = 0; i < 4; i++)
                        if (mc_log[l0+i] !== base + 32'(4*i)) bad = 1'b1;
                if (bad) begin
                    failures++;
                    $display("FAIL fill_seq pc=%h: %0d reads, first %h, required 4 reads from %h",
                             pc, mc_log.size() - l0,
                             (mc_log.size() > l0) ? mc_log[l0] : 32'hFFFF_FFFF, base);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.if_done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse pc=%h: if_done=%b one cycle later, required 0", pc, bus.if_done);
        end
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        bus.if_en = 1'b0;
        bus.if_pc = '0;
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        foreach (mtag[i]) mtag[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.if_done !== 1'b0 || bus.if_data !== 32'h0 || bus.mc_en !== 1'b0 || bus.mc_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: done=%b data=%h mc_en=%b mc_pc=%h, required all 0",
                     bus.if_done, bus.if_data, bus.mc_en, bus.mc_pc);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.if_done !== 1'b0 || bus.mc_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: done=%b mc_en=%b after release, required 0/0", bus.if_done, bus.mc_en);
        end
    endtask

    task automatic test_fill_hit();
        do_fetch(32'h10);
        do_fetch(32'h18);
    endtask

    task automatic test_conflict();
        do_fetch(32'h110);
        do_fetch(32'h10);
        do_fetch(32'h1C);
    endtask

    task automatic test_rollback_fill();
        int l0, cyc;
        bit reached, saw_done;
        @(negedge clk);
        l0 = mc_log.size();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h40;
        reached = 1'b0;
        cyc = 0;
        while (!reached && cyc < 200) begin
            @(negedge clk);
            cyc++;
            reached = (mc_log.size() - l0 == 2) && (bus.mc_en === 1'b1);
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL rb_fill_reach: word 2 request not seen in %0d cycles, required it", cyc);
        end
        rollback = 1'b1;
        bus.if_en = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        saw_done = (bus.if_done === 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (mc_log.size() - l0 != 3 || mc_log[mc_log.size()-1] !== 32'h48) begin
            failures++;
            $display("FAIL rb_fill_hold: %0d reads last %h, required 3 reads ending at 00000048",
                     mc_log.size() - l0, mc_log[mc_log.size()-1]);
        end
        checks++;
        if (saw_done || bus.mc_en !== 1'b0) begin
            failures++;
            $display("FAIL rb_fill_quiet: if_done seen=%b mc_en=%b, required 0/0", saw_done, bus.mc_en);
        end
        mvalid[4] = 1'b0;
        do_fetch(32'h40);
    endtask

    task automatic test_rollback_hit();
        int l0;
        bit bad;
        @(negedge clk);
        l0 = mc_log.size();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h18;
        rollback = 1'b1;
        @(negedge clk);
        bus.if_en = 1'b0;
        rollback = 1'b0;
        bad = (bus.if_done !== 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.if_done !== 1'b0 || bus.mc_en !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || mc_log.size() != l0) begin
            failures++;
            $display("FAIL rb_hit: response or memory read after rollback, required none");
        end
        do_fetch(32'h18);
    endtask

    task automatic test_rdy_stall();
        int l0, cyc;
        bit reached, bad, got;
        logic        s_en, s_done;
        logic [31:0] s_pc, s_data;
        @(negedge clk);
        l0 = mc_log.size();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h200;
        reached = 1'b0;
        cyc = 0;
        while (!reached && cyc < 200) begin
            @(negedge clk);
            cyc++;
            reached = (mc_log.size() - l0 == 1) && (bus.mc_en === 1'b1);
        end
        rdy = 1'b0;
        s_en = bus.mc_en; s_pc = bus.mc_pc; s_done = bus.if_done; s_data = bus.if_data;
        bad = !reached;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mc_en !== s_en || bus.mc_pc !== s_pc || bus.if_done !== s_done || bus.if_data !== s_data)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rdy_freeze: mc_en=%b mc_pc=%h, required frozen at %b/%h", bus.mc_en, bus.mc_pc, s_en, s_pc);
        end
        rdy = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = (bus.if_done === 1'b1);
        end
        bus.if_en = 1'b0;
        checks++;
        if (!got || bus.if_data !== mem_word(32'h200)) begin
            failures++;
            $display("FAIL rdy_resume: done=%b data=%h, required 1/%h", got, bus.if_data, mem_word(32'h200));
        end
        bad = (mc_log.size() - l0 != 4);
        if (!bad)
            for (int i = 0; i < 4; i++)
                if (mc_log[l0+i] !== 32'h200 + 32'(4*i)) bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rdy_fill_seq: %0d reads, required 4 reads 00000200..0000020c", mc_log.size() - l0);
        end
        @(negedge clk);
        mvalid[0] = 1'b1;
        mtag[0]   = 24'h2;
    endtask

    task automatic test_reset_mid_fill();
        int l0, cyc;
        bit reached;
        do_fetch(32'h10);
        @(negedge clk);
        l0 = mc_log.size();
        bus.if_en = 1'b1;
        bus.if_pc = 32'h300;
        reached = 1'b0;
        cyc = 0;
        while (!reached && cyc < 200) begin
            @(negedge clk);
            cyc++;
            reached = (mc_log.size() - l0 >= 1) && (bus.mc_en === 1'b1);
        end
        rst = 1'b1;
        bus.if_en = 1'b0;
        #1;
        checks++;
        if (!reached || bus.mc_en !== 1'b0 || bus.mc_pc !== 32'h0 || bus.if_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_fill: reached=%b mc_en=%b mc_pc=%h, required 1/0/00000000",
                     reached, bus.mc_en, bus.mc_pc);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        do_fetch(32'h10);
        do_fetch(32'h300);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 40; n++) begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            do_fetch(pc);
        end
    endtask

    initial begin
        test_reset();
        test_fill_hit();
        test_conflict();
        test_rollback_fill();
        test_rollback_hit();
        test_rdy_stall();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
